// File: rtl/vram_arbiter_pkg.sv
// Shared types for the VRAM arbiter: requester port indices, sequencer states
// and a one-hot to port-index helper.
package vram_arbiter_pkg;

  typedef enum logic [1:0] {ARB_SCR, ARB_CPU, ARB_UP, ARB_DMA} arb_port_t;

  typedef enum logic [1:0] {ARB_IDLE, ARB_SETUP, ARB_STROBE, ARB_HOLD} arb_state_t;

  function automatic arb_port_t onehot_to_port(input logic [3:0] oh);
    arb_port_t p;
    p = ARB_SCR;
    if (oh[1]) p = ARB_CPU;
    if (oh[2]) p = ARB_UP;
    if (oh[3]) p = ARB_DMA;
    return p;
  endfunction

endpackage

// File: rtl/vram_arb_pick.sv
// Combinational fixed-priority picker: SCR > CPU > UP > DMA, or
// SCR > DMA > CPU > UP while the DMA starvation promote flag is set.
module vram_arb_pick (
  input  logic [3:0] elig,
  input  logic       promote,
  output logic [3:0] win
);

  always_comb begin
    win = 4'b0000;
    if (elig[0])                 win = 4'b0001;
    else if (promote && elig[3]) win = 4'b1000;
    else if (elig[1])            win = 4'b0010;
    else if (elig[2])            win = 4'b0100;
    else if (elig[3])            win = 4'b1000;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Shared SRAM arbiter and cycle sequencer (IDLE -> SETUP -> STROBE -> [HOLD]).
// Define VRAM_ARBITER_DMA_EN to arbitrate the DMA port and enable the starvation guard.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int STROBE_CYCLES = 1,
  parameter int STARVE_LIMIT  = 15
) (
  input  logic             clk28,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       we,
  input  logic [3:0][18:0] addr,
  input  logic [3:0][7:0]  wdata,
  output logic [3:0]       gnt,
  output logic [3:0]       done,
  output logic [7:0]       rdata,
  output logic [18:0]      va,
  output logic [7:0]       vd_out,
  output logic             vd_oe,
  input  logic [7:0]       vd_in,
  output logic             n_vrd,
  output logic             n_vwr
);

  localparam int SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

  arb_state_t    state, state_next;
  arb_port_t     port, win_port;
  logic          cur_we;
  logic [SW-1:0] stb_cnt;
  logic          strobe_last;
  logic [3:0]    elig, win;
  logic          promote;

`ifdef VRAM_ARBITER_DMA_EN
  logic [3:0] starve_cnt;

  assign elig    = req & ~done;
  assign promote = (starve_cnt == 4'(STARVE_LIMIT));

  // Only losses to CPU/UP count; a loss to SCR leaves the count unchanged.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst)                                  starve_cnt <= 4'd0;
    else if (!req[3])                         starve_cnt <= 4'd0;
    else if (state == ARB_IDLE && win[3])     starve_cnt <= 4'd0;
    else if (state == ARB_IDLE && elig[3] && (win[1] || win[2]) && !promote)
                                              starve_cnt <= starve_cnt + 4'd1;
  end
`else
  assign elig    = req & ~done & 4'b0111;
  // DMA port absent; promote never set for a legal STARVE_LIMIT
  assign promote = (STARVE_LIMIT == 0);
`endif

  vram_arb_pick u_pick (
    .elig    (elig),
    .promote (promote),
    .win     (win)
  );

  assign win_port    = onehot_to_port(win);
  assign strobe_last = (stb_cnt == '0);

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) state <= ARB_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ARB_IDLE:   if (|win) state_next = ARB_SETUP;
      ARB_SETUP:  state_next = ARB_STROBE;
      ARB_STROBE: if (strobe_last) state_next = cur_we ? ARB_HOLD : ARB_IDLE;
      ARB_HOLD:   state_next = ARB_IDLE;
      default:    state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      port    <= ARB_SCR;
      cur_we  <= 1'b0;
      stb_cnt <= '0;
      gnt     <= 4'b0000;
      done    <= 4'b0000;
      rdata   <= 8'h00;
      va      <= 19'h0;
      vd_out  <= 8'h00;
      vd_oe   <= 1'b0;
      n_vrd   <= 1'b1;
      n_vwr   <= 1'b1;
    end else begin
      done <= 4'b0000;
      case (state)
        ARB_IDLE: if (|win) begin
          port   <= win_port;
          cur_we <= we[win_port];
          gnt    <= win;
          va     <= addr[win_port];
          if (we[win_port]) vd_out <= wdata[win_port];
          vd_oe  <= we[win_port];
        end
        ARB_SETUP: begin
          n_vrd   <= cur_we;
          n_vwr   <= !cur_we;
          stb_cnt <= SW'(STROBE_CYCLES - 1);
        end
        ARB_STROBE: begin
          if (strobe_last) begin
            n_vrd      <= 1'b1;
            n_vwr      <= 1'b1;
            gnt        <= 4'b0000;
            done[port] <= 1'b1;
            if (!cur_we) rdata <= vd_in;
          end else begin
            stb_cnt <= stb_cnt - 1'b1;
          end
        end
        ARB_HOLD: vd_oe <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: SRAM model, completion scoreboard and
// per-scenario directed tasks.
module tb_vram_arbiter;

  localparam int STROBE = 1;
  localparam int LIMIT  = 3;

  logic             clk28 = 1'b0;
  logic             rst;
  logic [3:0]       req, we;
  logic [3:0][18:0] addr;
  logic [3:0][7:0]  wdata;
  logic [3:0]       gnt, done;
  logic [7:0]       rdata, vd_out, vd_in;
  logic [18:0]      va;
  logic             vd_oe, n_vrd, n_vwr;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] port_oh;
    bit         is_read;
    logic [7:0] data;
  } exp_t;
  exp_t sb[$];

  logic [7:0] mem [0:255];

  vram_arbiter #(.STROBE_CYCLES(STROBE), .STARVE_LIMIT(LIMIT)) dut (
    .clk28(clk28), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .va(va), .vd_out(vd_out),
    .vd_oe(vd_oe), .vd_in(vd_in), .n_vrd(n_vrd), .n_vwr(n_vwr)
  );

  always #5 clk28 = ~clk28;

  function automatic logic [7:0] h(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ {5'b0, a[18:16]};
  endfunction

  // SRAM model: read data visible only while n_vrd is low, write on clock while n_vwr low
  always_comb vd_in = n_vrd ? 8'h00 : mem[h(va)];
  always @(posedge clk28) if (!n_vwr) mem[h(va)] <= vd_out;

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk28) begin
    if (done !== 4'b0000) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: done=%b with no access outstanding", done);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (done !== e.port_oh) begin
          errors++;
          $display("FAIL sb_port: done=%b expected %b", done, e.port_oh);
        end
        if (e.is_read) begin
          checks++;
          if (rdata !== e.data) begin
            errors++;
            $display("FAIL sb_rdata: rdata=%h expected %h", rdata, e.data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk28);
    #1;
  endtask

  task automatic push_read(input int p, input logic [18:0] a);
    exp_t e;
    e.port_oh = 4'(1 << p);
    e.is_read = 1'b1;
    e.data    = mem[h(a)];
    sb.push_back(e);
  endtask

  task automatic wait_done(input int p, input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      tick();
      if (done[p]) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt: %b expected 0000", gnt); end
    checks++; if (done !== 4'b0) begin errors++; $display("FAIL reset_done: %b expected 0000", done); end
    checks++; if (va !== 19'h0) begin errors++; $display("FAIL reset_va: %h expected 0", va); end
    checks++; if ({n_vrd, n_vwr, vd_oe} !== 3'b110) begin errors++; $display("FAIL reset_pins: rd/wr/oe=%b expected 110", {n_vrd, n_vwr, vd_oe}); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: %h expected 00", rdata); end
  endtask

  task automatic test_single_read();
    mem[h(19'h12345)] = 8'hA5;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 19'h12345;
    push_read(1, 19'h12345);
    tick();  // E0
    checks++; if (gnt !== 4'b0010 || va !== 19'h12345) begin errors++; $display("FAIL read_setup: gnt=%b va=%h expected 0010/12345", gnt, va); end
    checks++; if (n_vrd !== 1'b1 || vd_oe !== 1'b0) begin errors++; $display("FAIL read_setup_pins: n_vrd=%b vd_oe=%b expected 1/0", n_vrd, vd_oe); end
    tick();  // E1
    checks++; if (n_vrd !== 1'b0 || n_vwr !== 1'b1) begin errors++; $display("FAIL read_strobe: n_vrd=%b n_vwr=%b expected 0/1", n_vrd, n_vwr); end
    tick();  // E2
    checks++; if (done !== 4'b0010 || gnt !== 4'b0 || n_vrd !== 1'b1) begin errors++; $display("FAIL read_done: done=%b gnt=%b n_vrd=%b expected 0010/0000/1", done, gnt, n_vrd); end
    checks++; if (rdata !== 8'hA5) begin errors++; $display("FAIL read_rdata: %h expected a5", rdata); end
    req[1] = 1'b0;
    tick();
  endtask

  task automatic test_collision();
    int t0, t1;
    t0 = -1; t1 = -1;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 19'h00100;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 19'h2ABCD;
    push_read(0, 19'h00100);
    push_read(1, 19'h2ABCD);
    for (int c = 1; c <= 20 && t1 < 0; c++) begin
      tick();
      if (c == 1) begin
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL coll_first_gnt: %b expected 0001", gnt); end
      end
      if (done[0]) begin t0 = c; req[0] = 1'b0; end
      if (done[1]) begin t1 = c; req[1] = 1'b0; end
    end
    req[1:0] = 2'b00;
    checks++;
    if (t0 < 0 || t1 < 0 || (t1 - t0) != 3) begin
      errors++; $display("FAIL coll_pitch: scr_done@%0d cpu_done@%0d expected gap 3", t0, t1);
    end
    tick();
  endtask

  task automatic test_write_framing();
    exp_t e;
    bit seen;
    e.port_oh = 4'b0100; e.is_read = 1'b0; e.data = 8'h00;
    sb.push_back(e);
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 19'h00040; wdata[2] = 8'h3C;
    tick();  // E0: cycle before strobe
    checks++; if (va !== 19'h00040 || vd_out !== 8'h3C || vd_oe !== 1'b1 || n_vwr !== 1'b1) begin errors++; $display("FAIL wr_setup: va=%h vd=%h oe=%b n_vwr=%b expected 00040/3c/1/1", va, vd_out, vd_oe, n_vwr); end
    tick();  // E1: strobe
    checks++; if (n_vwr !== 1'b0 || n_vrd !== 1'b1 || va !== 19'h00040 || vd_out !== 8'h3C) begin errors++; $display("FAIL wr_strobe: n_vwr=%b n_vrd=%b va=%h vd=%h expected 0/1/00040/3c", n_vwr, n_vrd, va, vd_out); end
    tick();  // E2: hold
    checks++; if (n_vwr !== 1'b1 || done !== 4'b0100 || gnt !== 4'b0) begin errors++; $display("FAIL wr_hold: n_vwr=%b done=%b gnt=%b expected 1/0100/0000", n_vwr, done, gnt); end
    checks++; if (va !== 19'h00040 || vd_out !== 8'h3C || vd_oe !== 1'b1) begin errors++; $display("FAIL wr_hold_bus: va=%h vd=%h oe=%b expected 00040/3c/1", va, vd_out, vd_oe); end
    req[2] = 1'b0; we[2] = 1'b0;
    tick();  // back in IDLE
    checks++; if (vd_oe !== 1'b0 || done !== 4'b0) begin errors++; $display("FAIL wr_release: oe=%b done=%b expected 0/0000", vd_oe, done); end
    e.port_oh = 4'b0010; e.is_read = 1'b1; e.data = 8'h3C;
    sb.push_back(e);
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 19'h00040;
    wait_done(1, 10, seen);
    req[1] = 1'b0;
    checks++; if (!seen) begin errors++; $display("FAIL wr_readback_timeout: no done[1] within 10 cycles"); end
    tick();
  endtask

  task automatic test_handshake();
    bit seen;
    int grants;
    grants = 0;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 19'h00777;
    push_read(1, 19'h00777);
    wait_done(1, 10, seen);
    checks++; if (!seen) begin errors++; $display("FAIL hs_timeout: no done[1] within 10 cycles"); end
    for (int i = 0; i < 6; i++) begin
      tick();
      if (i == 0) req[1] = 1'b0;
      if (gnt !== 4'b0) grants++;
    end
    checks++; if (grants != 0) begin errors++; $display("FAIL hs_duplicate: %0d grant cycles after done, expected 0", grants); end
  endtask

`ifdef VRAM_ARBITER_DMA_EN
  task automatic test_dma();
    bit seen;
    seen = 1'b0;
    req[3:1] = 3'b111; we[3:1] = 3'b000;
    addr[1] = 19'h01111; addr[2] = 19'h02222; addr[3] = 19'h03333;
    push_read(1, 19'h01111);
    push_read(2, 19'h02222);
    push_read(1, 19'h01111);
    push_read(3, 19'h03333);
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (done[3]) begin seen = 1'b1; req[3:1] = 3'b000; end
    end
    req[3:1] = 3'b000;
    checks++; if (!seen) begin errors++; $display("FAIL dma_timeout: DMA never completed within 40 cycles"); end
    checks++; if (dut.starve_cnt !== 4'd0) begin errors++; $display("FAIL dma_cnt_clear: %0d expected 0", dut.starve_cnt); end
    repeat (4) tick();
  endtask
`else
  task automatic test_dma();
    int hits;
    hits = 0;
    req[3] = 1'b1; we[3] = 1'b0; addr[3] = 19'h03333;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (gnt !== 4'b0 || done !== 4'b0) hits++;
    end
    req[3] = 1'b0;
    checks++; if (hits != 0) begin errors++; $display("FAIL dma_ignored: %0d cycles with gnt/done activity, expected 0", hits); end
  endtask
`endif

  task automatic test_reset_mid_strobe();
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 19'h1F0F0; wdata[2] = 8'h99;
    tick();  // E0
    tick();  // E1: write strobe active
    checks++; if (n_vwr !== 1'b0) begin errors++; $display("FAIL mid_pre: n_vwr=%b expected 0", n_vwr); end
    #2 rst = 1'b1;
    #1;
    checks++; if (n_vwr !== 1'b1 || vd_oe !== 1'b0 || gnt !== 4'b0) begin errors++; $display("FAIL mid_async: n_vwr=%b oe=%b gnt=%b expected 1/0/0000", n_vwr, vd_oe, gnt); end
    req[2] = 1'b0; we[2] = 1'b0;
    @(negedge clk28);
    rst = 1'b0;
    tick();
    checks++; if (va !== 19'h0 || vd_out !== 8'h00 || rdata !== 8'h00) begin errors++; $display("FAIL mid_after_va_vd_rdata: %h/%h/%h expected 0/0/0", va, vd_out, rdata); end
    checks++; if ({n_vrd, n_vwr, vd_oe} !== 3'b110 || gnt !== 4'b0 || done !== 4'b0) begin errors++; $display("FAIL mid_after_ctl: rd/wr/oe=%b gnt=%b done=%b expected 110/0000/0000", {n_vrd, n_vwr, vd_oe}, gnt, done); end
    repeat (3) tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 37 + 11);
    test_reset();
    test_single_read();
    test_collision();
    test_write_framing();
    test_handshake();
    test_dma();
    test_reset_mid_strobe();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL sb_drain: %0d accesses never completed, expected 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Arbiter and cycle sequencer for the shared external video/main SRAM (va/vd/n_vrd/n_vwr). It sits between the memory controller's requesters and the SRAM pins and serialises their accesses into properly timed SRAM cycles. The requesters are the screen fetcher, the CPU path, the ULA+ palette write-back and an optional DMA channel. Screen fetch has absolute priority, and the remaining requesters use fixed priority with a starvation guard for DMA.

## Interface
Parameters:
- STROBE_CYCLES, default 1: clk28 cycles n_vrd/n_vwr are held low; minimum 1.
- STARVE_LIMIT, default 15: consecutive lost arbitrations after which DMA is promoted; range 1..15, 4-bit counter.

Ports:
- clk28  in  1  system clock; one clock.
- rst  in  1  reset; asynchronous, active-high.
- req  in  4  request per port; index SCR=0, CPU=1, UP=2, DMA=3.
- we  in  4  per-port write flag; sampled with req.
- addr  in  4x19  per-port address, packed [3:0][18:0].
- wdata  in  4x8  per-port write data.
- gnt  out  4  one-hot; high from SETUP until the access ends.
- done  out  4  one-cycle completion pulse per port.
- rdata  out  8  last read data; shared by all ports.
- va  out  19  SRAM address.
- vd_out  out  8  SRAM write data.
- vd_oe  out  1  drive vd.
- vd_in  in  8  SRAM read data.
- n_vrd  out  1  SRAM read strobe, active-low.
- n_vwr  out  1  SRAM write strobe, active-low.

## Operation
- States: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - Arbitrate among eligible req bits.
  - req[i] is ignored while done[i]=1.
  - On a winner, latch port/we/addr/wdata, set gnt, go to SETUP.
  - With no eligible requester, stay in IDLE.
- Priority: SCR > CPU > UP > DMA.
  - When the starvation counter is at STARVE_LIMIT, priority becomes SCR > DMA > CPU > UP.
- SETUP: va driven; vd_out/vd_oe driven for writes; both strobes high. Always one cycle.
- STROBE:
  - n_vrd=0 for a read, n_vwr=0 for a write.
  - Lasts STROBE_CYCLES cycles.
  - A read samples vd_in into rdata on the edge ending the last STROBE cycle, then goes to IDLE with done[i]=1.
  - A write goes to HOLD.
- HOLD (write only): strobes high, va/vd_out/vd_oe held, done[i]=1, then IDLE. vd_oe drops on entry to IDLE.
- gnt clears on the same edge that raises done.
- Requester handshake:
  - Hold req, we, addr and wdata stable from assertion until done.
  - Deassert req by the edge ending the done cycle.
  - An ungranted req stays pending; there is no abort.
- Starvation counter:
  - Increments on each IDLE arbitration where DMA requests and loses to CPU or UP.
  - Clears when DMA is granted or DMA req is low.
  - Saturates at STARVE_LIMIT.
  - A loss to SCR does not increment it.
- Reset values: state IDLE; va=0, vd_out=0, vd_oe=0, n_vrd=1, n_vwr=1, gnt=0, done=0, rdata=0, counter=0.
- Reset mid-access: strobes go high and vd_oe goes low asynchronously. No done is issued, and the access is lost.
- Bandwidth: the screen controller guarantees at most one SCR request per 2+STROBE_CYCLES window. The arbiter does not check this.

## Timing
- Edge E0 is the IDLE edge that grants.
- Read:
  - SETUP runs E0..E1.
  - STROBE runs E1..E1+S.
  - rdata is valid and done is high from E1+S.
  - Occupancy is 2+S cycles including the IDLE arbitration cycle.
  - Back-to-back reads run at 2+S cycle pitch.
- Write:
  - SETUP, then S STROBE cycles, then HOLD with done.
  - Occupancy is 3+S cycles.
  - va/vd are stable one cycle before and one cycle after n_vwr low.
- Strobes and vd_oe are registered outputs; there is no combinational path from req to the pins.
- Worst-case CPU wait with no SCR collision is one in-flight write: 3+S cycles before its own SETUP.

## Configuration
- VRAM_ARBITER_DMA_EN defined:
  - The DMA port is arbitrated.
  - The starvation counter is present.
- Undefined:
  - req[3] is ignored.
  - gnt[3] and done[3] are tied to 0.
  - There is no counter, and priority is fixed at SCR > CPU > UP.

## Structure
- In package common:
  - typedef enum arb_port_t {ARB_SCR, ARB_CPU, ARB_UP, ARB_DMA}.
  - typedef enum arb_state_t {ARB_IDLE, ARB_SETUP, ARB_STROBE, ARB_HOLD}.
- One sub-module, vram_arb_pick:
  - Combinational priority picker.
  - Inputs: eligible req vector and starve-promote flag.
  - Output: one-hot winner.
- The FSM, counters and SRAM pin registers live in vram_arbiter.

## Test plan
- **Reset mid-strobe:** assert rst during a write STROBE. n_vwr=1 and vd_oe=0 immediately; no done; after release, all outputs are at reset values.
- **Single CPU read** (S=1, addr=0x12345, SRAM returns 0xA5): SETUP at E0, n_vrd low E1..E2, done[1] and rdata=0xA5 at E2.
- **SCR/CPU collision:** SCR and CPU req in the same IDLE cycle. SCR granted first; CPU done arrives 3 cycles after SCR done (S=1, both reads).
- **Write framing** (UP write 0x3C to 0x00040): va/vd stable the cycle before and the cycle after the single n_vwr-low cycle; done[2] in HOLD.
- **DMA starvation** (DMA_EN, STARVE_LIMIT=3): CPU requests continuously alongside DMA. After 3 lost arbitrations DMA is granted ahead of CPU, and the counter clears.
- **Handshake:** requester keeps req high one cycle past done. Exactly one access is performed; no duplicate grant.
